// File: rtl/shift_ctrl_pkg.sv
// Shared state and mode encodings for the LED shift sequencer.
package shift_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MODE_RIGHT  = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BTN    = 2'b11
    } mode_t;

endpackage

// File: rtl/tick_prescaler.sv
// Rate prescaler: emits a one-cycle tick every LIMIT_[i_speed] cycles while i_run is high.
module tick_prescaler #(
    parameter int unsigned NB_COUNT = 32,
    parameter int unsigned LIMIT_0  = 2**23,
    parameter int unsigned LIMIT_1  = 2**24,
    parameter int unsigned LIMIT_2  = 2**25,
    parameter int unsigned LIMIT_3  = 2**26
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_run,
    input  logic [1:0] i_speed,
    output logic       o_tick
);

    localparam logic [NB_COUNT-1:0] LIM_0 = NB_COUNT'(LIMIT_0);
    localparam logic [NB_COUNT-1:0] LIM_1 = NB_COUNT'(LIMIT_1);
    localparam logic [NB_COUNT-1:0] LIM_2 = NB_COUNT'(LIMIT_2);
    localparam logic [NB_COUNT-1:0] LIM_3 = NB_COUNT'(LIMIT_3);

    logic [NB_COUNT-1:0] cnt;
    logic [NB_COUNT-1:0] limit;

    always_comb begin
        limit = LIM_3;
        case (i_speed)
            2'b00:   limit = LIM_0;
            2'b01:   limit = LIM_1;
            2'b10:   limit = LIM_2;
            default: limit = LIM_3;
        endcase
    end

    // '>=' rather than '==' so a speed drop below the current count fires at once
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_run) begin
            cnt    <= '0;
            o_tick <= 1'b0;
        end else if (cnt >= limit - NB_COUNT'(1)) begin
            cnt    <= '0;
            o_tick <= 1'b1;
        end else begin
            cnt    <= cnt + NB_COUNT'(1);
            o_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_ctrl.sv
// LED shift sequencer: run/pause FSM, prescaled shift enable and direction selection.
import shift_ctrl_pkg::*;

module shift_ctrl #(
    parameter int          n_LEDS   = 4,
    parameter int unsigned NB_COUNT = 32,
    parameter int unsigned LIMIT_0  = 2**23,
    parameter int unsigned LIMIT_1  = 2**24,
    parameter int unsigned LIMIT_2  = 2**25,
    parameter int unsigned LIMIT_3  = 2**26
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [1:0]        i_speed,
    input  logic [1:0]        i_mode,
    input  logic              i_btn,
    input  logic [n_LEDS-1:0] i_led,
    output logic              o_valid,
    output logic              o_dir,
    output logic              o_run
);

    state_t state;
    state_t state_next;
    logic   btn_d;
    logic   dir_next;
    logic   run_now;
    logic   unused_led;

    assign unused_led = ^i_led;

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (i_enable)  state_next = ST_RUN;
            ST_RUN:  if (!i_enable) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign o_run = (state == ST_RUN);

    // Counting only while staying in RUN keeps the leaving edge pulse-free and
    // makes the first tick land exactly one period after entering RUN.
    assign run_now = (state == ST_RUN) && i_enable;

    tick_prescaler #(
        .NB_COUNT (NB_COUNT),
        .LIMIT_0  (LIMIT_0),
        .LIMIT_1  (LIMIT_1),
        .LIMIT_2  (LIMIT_2),
        .LIMIT_3  (LIMIT_3)
    ) u_presc (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_run   (run_now),
        .i_speed (i_speed),
        .o_tick  (o_valid)
    );

    always_comb begin
        dir_next = o_dir;
        case (mode_t'(i_mode))
            MODE_RIGHT: dir_next = 1'b0;
            MODE_LEFT:  dir_next = 1'b1;
            MODE_BOUNCE: begin
                if (o_dir && i_led[n_LEDS-1])  dir_next = 1'b0;
                else if (!o_dir && i_led[0])   dir_next = 1'b1;
            end
            MODE_BTN:   if (i_btn && !btn_d) dir_next = !o_dir;
            default:    dir_next = o_dir;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_dir <= 1'b0;
            btn_d <= 1'b0;
        end else begin
            o_dir <= dir_next;
            btn_d <= i_btn;
        end
    end

endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl: directed scenarios plus randomized run against a cycle model.
module tb_shift_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [1:0]   speed;
    logic [1:0]   mode;
    logic         btn;
    logic [N-1:0] sr;
    logic         valid;
    logic         dir;
    logic         run;

    int unsigned  lims [4] = '{4, 6, 8, 10};

    bit           m_run;
    int unsigned  m_cnt;
    bit           m_valid;
    bit           m_dir;
    bit           m_btn_d;
    logic [N-1:0] m_led;
    bit           prev_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_ctrl #(
        .n_LEDS   (N),
        .NB_COUNT (32),
        .LIMIT_0  (4),
        .LIMIT_1  (6),
        .LIMIT_2  (8),
        .LIMIT_3  (10)
    ) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_enable (enable),
        .i_speed  (speed),
        .i_mode   (mode),
        .i_btn    (btn),
        .i_led    (sr),
        .o_valid  (valid),
        .o_dir    (dir),
        .o_run    (run)
    );

    function automatic logic [N-1:0] rot(input logic [N-1:0] l, input bit d);
        return d ? {l[N-2:0], l[N-1]} : {l[0], l[N-1:1]};
    endfunction

    // Board shift register, driven by the DUT outputs.
    always @(posedge clk) begin
        if (reset)      sr <= 4'b0001;
        else if (valid) sr <= rot(sr, dir);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit           n_run, n_valid, n_dir;
        int unsigned  n_cnt;
        logic [N-1:0] n_led;
        if (reset) begin
            n_run = 0; n_cnt = 0; n_valid = 0; n_dir = 0; n_led = 4'b0001;
        end else begin
            n_led = m_valid ? rot(m_led, m_dir) : m_led;
            n_run = enable;
            if (m_run && enable) begin
                n_valid = (m_cnt + 1 >= lims[speed]);
                n_cnt   = n_valid ? 0 : m_cnt + 1;
            end else begin
                n_valid = 0; n_cnt = 0;
            end
            n_dir = m_dir;
            case (mode)
                2'd0: n_dir = 0;
                2'd1: n_dir = 1;
                2'd2: if (m_dir && m_led[N-1]) n_dir = 0;
                      else if (!m_dir && m_led[0]) n_dir = 1;
                default: if (btn && !m_btn_d) n_dir = !m_dir;
            endcase
        end
        @(posedge clk);
        #1;
        m_btn_d = reset ? 1'b0 : btn;
        m_run = n_run; m_cnt = n_cnt; m_valid = n_valid; m_dir = n_dir; m_led = n_led;
        chk("valid", 32'(valid), 32'(m_valid));
        chk("dir",   32'(dir),   32'(m_dir));
        chk("run",   32'(run),   32'(m_run));
        chk("led",   32'(sr),    32'(m_led));
        chk("no_double_valid", 32'(valid & prev_v), 32'd0);
        prev_v = valid;
    endtask

    logic [N-1:0] bexp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    initial begin
        int  idx;
        bit  d0;
        m_led = 4'b0001; prev_v = 0;
        m_run = 0; m_cnt = 0; m_valid = 0; m_dir = 0; m_btn_d = 0;

        // reset with random inputs
        reset = 1; enable = 1'($urandom); speed = 2'($urandom);
        mode = 2'($urandom); btn = 1'($urandom);
        step(); step();
        chk("rst_cnt", dut.u_presc.cnt, 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);

        // fixed right, speed 00
        reset = 0; enable = 0; btn = 0; mode = 2'd0; speed = 2'd0;
        step();
        enable = 1;
        repeat (4) step();
        chk("first_tick_not_early", 32'(valid), 32'd0);
        step();
        chk("first_tick", 32'(valid), 32'd1);
        step();
        chk("led_1000", 32'(sr), 32'h8);
        repeat (3) step();
        chk("tick_period4", 32'(valid), 32'd1);
        step();
        chk("led_0100", 32'(sr), 32'h4);
        enable = 0;
        step();
        chk("pause_run", 32'(run), 32'd0);
        chk("pause_valid", 32'(valid), 32'd0);

        // speed change mid-count
        speed = 2'd3; enable = 1;
        for (int i = 0; i < 40 && !(m_run && m_cnt == 7); i++) step();
        chk("reach_cnt7", 32'(m_cnt), 32'd7);
        speed = 2'd0;
        step();
        chk("spd_tick", 32'(valid), 32'd1);
        repeat (4) step();
        chk("spd_period4", 32'(valid), 32'd1);

        // bounce from 0001
        reset = 1; step(); reset = 0;
        mode = 2'd2; speed = 2'd0; enable = 1;
        idx = 0;
        for (int i = 0; i < 80 && idx < 7; i++) begin
            step();
            if (valid) begin
                step();
                chk("bounce_led", 32'(sr), 32'(bexp[idx]));
                idx++;
            end
        end
        chk("bounce_count", idx, 32'd7);

        // button toggle: held button, then two pulses
        mode = 2'd3; enable = 0; btn = 0;
        step();
        d0 = m_dir;
        btn = 1;
        repeat (20) step();
        chk("btn_hold", 32'(dir), 32'(!d0));
        d0 = m_dir;
        btn = 0; step(); btn = 1; step(); btn = 0; step(); btn = 1; step(); btn = 0; step();
        chk("btn_two", 32'(dir), 32'(d0));

        // button edge coincident with tick
        enable = 1; speed = 2'd0;
        for (int i = 0; i < 20 && !(m_run && m_cnt == 3); i++) step();
        d0 = m_dir;
        btn = 1;
        step();
        chk("coinc_valid", 32'(valid), 32'd1);
        chk("coinc_dir", 32'(dir), 32'(!d0));
        btn = 0;
        repeat (2) step();

        // reset mid-run at cnt=3 with dir=1
        mode = 2'd1; speed = 2'd0; enable = 1;
        for (int i = 0; i < 20 && !(m_run && m_cnt == 3 && m_dir); i++) step();
        reset = 1;
        step();
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_dir", 32'(dir), 32'd0);
        chk("midrst_run", 32'(run), 32'd0);
        chk("midrst_cnt", dut.u_presc.cnt, 32'd0);
        reset = 0;

        // randomized run
        for (int i = 0; i < 600; i++) begin
            reset  = ($urandom_range(0, 79) == 0);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) speed = 2'($urandom);
            if ($urandom_range(0, 29) == 0) mode  = 2'($urandom);
            if ($urandom_range(0, 3) == 0)  btn   = 1'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
